// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending CPU stores drained to memory, with load hazard handling.
// Define STORE_FWD_EN to forward matching loads from the youngest buffered store instead of stalling.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic [31:0] cpu_data_addr_i,
   input  logic [31:0] cpu_data_wdata_i,
   input  logic        cpu_data_re_i,
   input  logic        cpu_data_we_i,
   output logic [31:0] cpu_data_rdata_o,
   output logic        cpu_stall_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_req_o,
   input  logic        mem_gnt_i,
   output logic [31:0] mem_raddr_o,
   input  logic [31:0] mem_rdata_i,
   output logic        empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0]    head_reg;
   logic [AW-1:0]    tail_reg;
   logic [AW:0]      count_reg;
   logic [DEPTH-1:0] valid_reg;
   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];

   logic             full;
   logic             push;
   logic             pop;
   logic             load;
   logic             hit;
   logic [DEPTH-1:0] match;

   assign full = (count_reg == FULL_CNT);
   // A store arriving while full is blocked for the whole cycle, even if a pop frees a slot.
   assign push = cpu_data_we_i && !full;
   assign pop  = (count_reg != '0) && mem_gnt_i;
   assign load = cpu_data_re_i && !cpu_data_we_i;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (addr_mem[gi] == cpu_data_addr_i);
   end

   assign hit = |match;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         valid_reg <= '0;
      end else begin
         if (pop) begin
            head_reg            <= head_reg + 1'b1;
            valid_reg[head_reg] <= 1'b0;
         end
         if (push) begin
            tail_reg            <= tail_reg + 1'b1;
            valid_reg[tail_reg] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry payload carries no reset; only the valid state matters after reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[tail_reg] <= cpu_data_addr_i;
         data_mem[tail_reg] <= cpu_data_wdata_i;
      end
   end

   assign mem_req_o   = (count_reg != '0);
   assign mem_addr_o  = addr_mem[head_reg];
   assign mem_wdata_o = data_mem[head_reg];
   assign mem_raddr_o = cpu_data_addr_i;
   assign empty_o     = (count_reg == '0);

`ifdef STORE_FWD_EN
   logic [31:0] fwd_data;

   // Walk from oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      logic [AW-1:0] idx;
      fwd_data = '0;
      idx      = head_reg;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_reg + AW'(k);
         if (match[idx]) begin
            fwd_data = data_mem[idx];
         end
      end
   end

   assign cpu_stall_o      = cpu_data_we_i && full;
   assign cpu_data_rdata_o = !load ? 32'h0 : (hit ? fwd_data : mem_rdata_i);
`else
   // Memory would return stale data while a matching store is still buffered.
   assign cpu_stall_o      = (cpu_data_we_i && full) || (load && hit);
   assign cpu_data_rdata_o = load ? mem_rdata_i : 32'h0;
`endif

endmodule
